// File: rtl/multdiv_pkg.sv
// Shared constants for the multiply/divide unit: opcodes, FSM encoding and default width.
package multdiv_pkg;

    localparam int unsigned LARGURA_PADRAO = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] CALCULA = 2'd1;
    localparam logic [1:0] AJUSTE  = 2'd2;

endpackage

// File: rtl/multdiv_datapath.sv
// Datapath of the mult/div unit: double-width accumulator, shift-add / restoring-division
// step and the sign fix-up applied to the final result.
module multdiv_datapath
    import multdiv_pkg::*;
#(
    parameter int unsigned LARGURA = LARGURA_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carrega,
    input  logic               passo,
    input  logic [2:0]         operacao,
    input  logic [LARGURA-1:0] operandoA,
    input  logic [LARGURA-1:0] operandoB,
    output logic [LARGURA-1:0] res_hi,
    output logic [LARGURA-1:0] res_lo
);

    logic [2*LARGURA-1:0] acc;
    logic [LARGURA-1:0]   oper_b;
    logic [LARGURA-1:0]   a_bruto;
    logic                 eh_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 div_zero;

    logic                 com_sinal;
    logic                 sinal_a;
    logic                 sinal_b;
    logic [LARGURA-1:0]   abs_a;
    logic [LARGURA-1:0]   abs_b;

    logic [LARGURA:0]     soma;
    logic [LARGURA:0]     resto_desl;
    logic [LARGURA:0]     dif;
    logic [2*LARGURA-1:0] mult_prox;
    logic [2*LARGURA-1:0] div_prox;

    always_comb begin
        com_sinal = (operacao == OP_MULT) || (operacao == OP_DIV);
        sinal_a   = com_sinal & operandoA[LARGURA-1];
        sinal_b   = com_sinal & operandoB[LARGURA-1];
        abs_a     = sinal_a ? -operandoA : operandoA;
        abs_b     = sinal_b ? -operandoB : operandoB;
    end

    // Multiply: multiplier sits in the low half and is consumed LSB first while the
    // partial product (with its carry) shifts in from the top.
    always_comb begin
        soma      = {1'b0, acc[2*LARGURA-1:LARGURA]} + {1'b0, oper_b};
        mult_prox = acc[0] ? {soma, acc[LARGURA-1:1]} : {1'b0, acc[2*LARGURA-1:1]};
    end

    // Divide: dif[LARGURA] is the borrow, set when the shifted remainder is below the divisor.
    always_comb begin
        resto_desl = acc[2*LARGURA-1:LARGURA-1];
        dif        = resto_desl - {1'b0, oper_b};
        div_prox   = dif[LARGURA] ? {resto_desl[LARGURA-1:0], acc[LARGURA-2:0], 1'b0}
                                  : {dif[LARGURA-1:0], acc[LARGURA-2:0], 1'b1};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc      <= '0;
            oper_b   <= '0;
            a_bruto  <= '0;
            eh_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (carrega) begin
            acc      <= {{LARGURA{1'b0}}, abs_a};
            oper_b   <= abs_b;
            a_bruto  <= operandoA;
            eh_div   <= operacao[1];
            neg_res  <= sinal_a ^ sinal_b;
            neg_rem  <= sinal_a;
            div_zero <= (operandoB == '0);
        end else if (passo) begin
            acc <= eh_div ? div_prox : mult_prox;
        end
    end

    logic [2*LARGURA-1:0] produto;
    logic [LARGURA-1:0]   resto;
    logic [LARGURA-1:0]   quoc;

    always_comb begin
        produto = neg_res ? -acc : acc;
        resto   = acc[2*LARGURA-1:LARGURA];
        quoc    = acc[LARGURA-1:0];
        res_hi  = produto[2*LARGURA-1:LARGURA];
        res_lo  = produto[LARGURA-1:0];
        if (eh_div) begin
            if (div_zero) begin
                res_hi = a_bruto;
                res_lo = '1;
            end else begin
                res_hi = neg_rem ? -resto : resto;
                res_lo = neg_res ? -quoc : quoc;
            end
        end
    end

endmodule

// File: rtl/unidade_multdiv.sv
// Iterative MIPS multiply/divide unit owning HI/LO; sequences the datapath through
// OCIOSO -> CALCULA (LARGURA steps) -> AJUSTE and handles MTHI/MTLO.
module unidade_multdiv
    import multdiv_pkg::*;
#(
    parameter int unsigned LARGURA = LARGURA_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic [2:0]         operacao,
    input  logic [LARGURA-1:0] operandoA,
    input  logic [LARGURA-1:0] operandoB,
    output logic               ocupado,
    output logic               pronto,
    output logic [LARGURA-1:0] HI,
    output logic [LARGURA-1:0] LO
);

    localparam int unsigned LCONT = $clog2(LARGURA) + 1;

    logic [1:0]         estado;
    logic [LCONT-1:0]   contador;
    logic               inicia_md;
    logic               passo;
    logic [LARGURA-1:0] res_hi;
    logic [LARGURA-1:0] res_lo;

    always_comb begin
        inicia_md = (estado == OCIOSO) && inicio && !operacao[2];
        passo     = (estado == CALCULA);
    end

    multdiv_datapath #(
        .LARGURA (LARGURA)
    ) u_datapath (
        .clock     (clock),
        .reset     (reset),
        .carrega   (inicia_md),
        .passo     (passo),
        .operacao  (operacao),
        .operandoA (operandoA),
        .operandoB (operandoB),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= OCIOSO;
            contador <= '0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    // Commands are only honoured here, so anything issued while busy is dropped.
                    if (inicio) begin
                        case (operacao)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                estado   <= CALCULA;
                                contador <= '0;
                                ocupado  <= 1'b1;
                            end
                            OP_MTHI: HI <= operandoA;
                            OP_MTLO: LO <= operandoA;
                            default: ;
                        endcase
                    end
                end
                CALCULA: begin
                    contador <= contador + LCONT'(1);
                    if (contador == LCONT'(LARGURA - 1)) begin
                        estado <= AJUSTE;
                    end
                end
                AJUSTE: begin
                    HI      <= res_hi;
                    LO      <= res_lo;
                    pronto  <= 1'b1;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_multdiv.sv
// Scoreboard bench for unidade_multdiv: stimulus pushes expected HI/LO and completion cycle,
// an independent monitor pops and checks them whenever pronto is seen.
module tb_unidade_multdiv;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        inicio;
    logic [2:0]  operacao;
    logic [31:0] operandoA;
    logic [31:0] operandoB;
    logic        ocupado;
    logic        pronto;
    logic [31:0] HI;
    logic [31:0] LO;

    unidade_multdiv #(
        .LARGURA (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .inicio    (inicio),
        .operacao  (operacao),
        .operandoA (operandoA),
        .operandoB (operandoB),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } esperado_t;

    esperado_t   fila[$];
    int          erros  = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          run    = 0;
    logic [31:0] hi_m   = '0;
    logic [31:0] lo_m   = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checa(input string nome, input logic [63:0] atual, input logic [63:0] req);
        checks++;
        if (atual !== req) begin
            erros++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nome, atual, req, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic, truncating signed division.
    task automatic modelo(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        logic        [63:0] p;
        logic signed [63:0] sa, sb, q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = '0;
        q  = '0;
        r  = '0;
        case (op)
            OP_MULT:  p = sa * sb;
            OP_MULTU: p = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 0) begin
                    q = -1;
                    r = {32'b0, a};
                end else if (op == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = {32'b0, a} / {32'b0, b};
                    r = {32'b0, a} % {32'b0, b};
                end
                p = {r[31:0], q[31:0]};
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endtask

    always @(negedge clock) begin
        if (pronto) begin
            if (fila.size() == 0) begin
                checa("pronto_inesperado", {63'b0, pronto}, 64'd0);
            end else begin
                esperado_t e;
                e = fila.pop_front();
                checa("HI", {32'b0, HI}, {32'b0, e.hi});
                checa("LO", {32'b0, LO}, {32'b0, e.lo});
                checa("latencia", 64'(cyc), 64'(e.due));
                checa("ocupado_com_pronto", {63'b0, ocupado}, 64'd0);
                checa("ciclos_ocupado", 64'(run), 64'd33);
            end
            run = 0;
        end else if (ocupado) begin
            run++;
        end else begin
            run = 0;
        end
    end

    task automatic pulso(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        operacao  = op;
        operandoA = a;
        operandoB = b;
        inicio    = 1'b1;
        @(negedge clock);
        inicio = 1'b0;
    endtask

    task automatic emite(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        esperado_t e;
        @(negedge clock);
        modelo(op, a, b, e.hi, e.lo);
        e.due = cyc + 34;
        fila.push_back(e);
        hi_m = e.hi;
        lo_m = e.lo;
        operacao  = op;
        operandoA = a;
        operandoB = b;
        inicio    = 1'b1;
        @(negedge clock);
        inicio = 1'b0;
    endtask

    task automatic espera_fim();
        for (int i = 0; i < 60 && fila.size() > 0; i++) @(negedge clock);
        checa("timeout_fila", 64'(fila.size()), 64'd0);
        fila.delete();
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        pulso(op, a, 32'h0);
        if (op == OP_MTHI) hi_m = a;
        else if (op == OP_MTLO) lo_m = a;
        checa("mt_HI", {32'b0, HI}, {32'b0, hi_m});
        checa("mt_LO", {32'b0, LO}, {32'b0, lo_m});
        checa("mt_pronto", {63'b0, pronto}, 64'd0);
        checa("mt_ocupado", {63'b0, ocupado}, 64'd0);
    endtask

    function automatic logic [31:0] operando_aleatorio();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset     = 1'b1;
        inicio    = 1'b0;
        operacao  = '0;
        operandoA = '0;
        operandoB = '0;
        repeat (3) @(negedge clock);
        checa("reset_HI", {32'b0, HI}, 64'd0);
        checa("reset_LO", {32'b0, LO}, 64'd0);
        checa("reset_ocupado", {63'b0, ocupado}, 64'd0);
        checa("reset_pronto", {63'b0, pronto}, 64'd0);
        reset = 1'b0;

        emite(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); espera_fim();
        emite(OP_MULT,  32'hFFFF_FFFD, 32'd5);         espera_fim();
        emite(OP_DIV,   32'hFFFF_FFF9, 32'd2);         espera_fim();
        emite(OP_DIVU,  32'd100,       32'd0);         espera_fim();
        emite(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF); espera_fim();
        emite(OP_DIV,   32'hFFFF_FFF9, 32'd0);         espera_fim();

        mt(OP_MTHI, 32'h1234_5678);
        mt(OP_MTLO, 32'hCAFE_0001);

        // Commands while busy must be dropped, including MTLO.
        emite(OP_DIVU, 32'd10, 32'd3);
        repeat (5) @(negedge clock);
        pulso(OP_MTLO, 32'h0000_AAAA, 32'h0);
        pulso(OP_MULT, 32'd5, 32'd5);
        espera_fim();
        repeat (40) @(negedge clock);
        checa("ocupado_ignora_LO", {32'b0, LO}, 64'd3);
        checa("ocupado_ignora_HI", {32'b0, HI}, 64'd1);

        // Reset mid-operation: no result and no pronto may follow.
        pulso(OP_MULTU, 32'd7, 32'd6);
        repeat (8) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        hi_m  = '0;
        lo_m  = '0;
        checa("aborto_HI", {32'b0, HI}, 64'd0);
        checa("aborto_LO", {32'b0, LO}, 64'd0);
        checa("aborto_ocupado", {63'b0, ocupado}, 64'd0);
        repeat (40) @(negedge clock);
        checa("aborto_HI_final", {32'b0, HI}, 64'd0);
        emite(OP_MULTU, 32'd7, 32'd6); espera_fim();

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (!op[2]) begin
                emite(op, operando_aleatorio(), operando_aleatorio());
                espera_fim();
            end else begin
                mt(op, $urandom);
            end
        end

        repeat (5) @(negedge clock);
        checa("fila_vazia", 64'(fila.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule

// File: doc/unidade_multdiv.md
Name: unidade_multdiv

Overview:
- Iterative multiply/divide unit fed directly by the register-file read ports (dadosLe1 → operandoA, dadosLe2 → operandoB) in the execute stage.
- Implements MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers.
- Uses a start/busy/done handshake so the control unit can stall while an operation runs.
- HI/LO outputs are consumed by MFHI/MFLO through the write-back mux.

Parameters:
LARGURA  32  operand width in bits. HI and LO are each LARGURA bits. The iteration count equals LARGURA.

Ports:
clock  input  1  single clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
inicio  input  1  start strobe; sampled on the rising edge of clock
operacao  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no effect)
operandoA  input  LARGURA  multiplicand/dividend; source value for MTHI/MTLO
operandoB  input  LARGURA  multiplier/divisor
ocupado  output  1  high while a mult/div operation is in progress
pronto  output  1  one-cycle pulse when HI/LO hold a new mult/div result
HI  output  LARGURA  HI register (product upper half / remainder)
LO  output  LARGURA  LO register (product lower half / quotient)

Behaviour:
- Reset (synchronous, active-high): state=OCIOSO, HI=0, LO=0, ocupado=0, pronto=0, counter=0.
- Reset has priority over every other input and aborts any operation in flight. No partial result reaches HI/LO.
- States:
  - OCIOSO: wait for a command.
  - CALCULA: 32 iterations, one per cycle.
  - AJUSTE: sign fix-up and HI/LO commit, 1 cycle.
- OCIOSO, inicio=1, operacao in {MULT, MULTU, DIV, DIVU} (sampled at edge k):
  - Latch |A| and |B| (signed ops) or A and B (unsigned ops).
  - Latch the result-sign flags; clear counter; go to CALCULA.
- CALCULA:
  - Multiply: shift-add, 1 bit per cycle.
  - Divide: restoring division, 1 quotient bit per cycle.
  - After 32 iterations (edges k+1..k+32), go to AJUSTE.
- AJUSTE (edge k+33): write HI/LO, set pronto=1 for exactly one cycle, return to OCIOSO.
- Timing:
  - ocupado=1 in the cycles following edges k..k+32 (33 cycles).
  - ocupado=0 in the cycle in which pronto=1.
  - Total latency from inicio sample to valid HI/LO is 34 cycles.
- OCIOSO, inicio=1, MTHI/MTLO: HI (or LO) ← operandoA at that edge. ocupado and pronto stay 0.
- Reserved operacao with inicio=1: no state change.
- inicio while ocupado=1: ignored entirely, including MTHI/MTLO. HI/LO are unchanged until AJUSTE.
- Signed multiply: 64-bit product negated when signA xor signB.
- Signed divide:
  - Quotient (LO) negative when signA xor signB.
  - Remainder (HI) takes the sign of operandoA.
- Division by zero, both signed and unsigned:
  - LO=all ones, HI=operandoA as latched (raw, not absolute value).
  - Full 34-cycle latency; no exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000 (wraps; no trap).
- HI/LO hold their value indefinitely between operations.

Decomposition:
- Shared package multdiv_pkg holds:
  - opcode constants OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO;
  - state encoding OCIOSO/CALCULA/AJUSTE;
  - the LARGURA default.
- One natural sub-module: multdiv_datapath.
  - Contains the 2×LARGURA accumulator/shift register, the add/subtract step and the sign fix-up logic.
  - Driven by the FSM in unidade_multdiv.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 34 cycles pronto=1, HI=0xFFFFFFFE, LO=0x00000001; ocupado high for exactly 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; then DIV A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 → LO=0xFFFFFFFF, HI=0x00000064. DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI A=0x12345678 while idle → HI=0x12345678 next cycle, pronto stays 0. Start DIVU 10/3, then pulse MTLO A=0xAAAA and MULT while busy → both ignored; final LO=3, HI=1.
- Start MULTU 7×6, assert reset at cycle 10 → next cycle HI=LO=0, ocupado=0, and no pronto pulse ever appears. New MULTU 7×6 then gives LO=42, HI=0.
